// File: rtl/uart_reg_bridge.sv
// ---------------------------------------------------------------------------
// uart_reg_bridge
//
// Turns the UART receive byte stream into register bus accesses and
// answers each access through the UART transmitter.
//
// Frame format (received):
//   0x55, CMD, ADDR                    read  (CMD = 0x00)
//   0x55, CMD, ADDR, D3, D2, D1, D0    write (CMD = 0x01), data MSB first
//
// Replies (transmitted):
//   write : 0xAA
//   read  : 0xAA, D3, D2, D1, D0
//
// Parameters
//   ADDR_W          register address width (1..32); the address byte is
//                   zero-extended or truncated to this width
//   TIMEOUT_CYCLES  max clock cycles between received bytes of one frame
//
// Optional build macro
//   INTER_BYTE_TIMEOUT_EN  when defined, a partial frame is abandoned after
//                          TIMEOUT_CYCLES cycles without a received byte;
//                          when undefined a partial frame waits forever
//
// Ports
//   ipClk       in   1       system clock
//   ipReset     in   1       synchronous reset, active-high
//   ipRxData    in   8       received byte
//   ipRxValid   in   1       one-cycle strobe, ipRxData valid
//   opTxData    out  8       byte to transmit
//   opTxSend    out  1       transmit request, held until ipTxBusy seen
//   ipTxBusy    in   1       transmitter busy
//   opAddress   out  ADDR_W  register address
//   opWrData    out  32      register write data
//   opWrEnable  out  1       one-cycle write strobe
//   opRdEnable  out  1       one-cycle read strobe
//   ipRdData    in   32      register read data
//   ipRdValid   in   1       one-cycle strobe, ipRdData valid
//
// State    | meaning
// ---------+------------------------------------------------------------
// IDLE     | hunting for the 0x55 sync byte
// CMD      | waiting for the command byte
// ADDR     | waiting for the address byte
// WDATA    | collecting the four write data bytes
// WRITE    | write strobe cycle
// READ     | read strobe cycle
// RD_WAIT  | waiting (unbounded) for read data
// REPLY    | transmitting the reply bytes one handshake at a time
// ---------------------------------------------------------------------------
module uart_reg_bridge #(
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 5_000_000
) (
    input  logic              ipClk,
    input  logic              ipReset,
    input  logic [7:0]        ipRxData,
    input  logic              ipRxValid,
    output logic [7:0]        opTxData,
    output logic              opTxSend,
    input  logic              ipTxBusy,
    output logic [ADDR_W-1:0] opAddress,
    output logic [31:0]       opWrData,
    output logic              opWrEnable,
    output logic              opRdEnable,
    input  logic [31:0]       ipRdData,
    input  logic              ipRdValid
);

    localparam logic [7:0] SYNC_BYTE = 8'h55;
    localparam logic [7:0] CMD_READ  = 8'h00;
    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] ACK_BYTE  = 8'hAA;

    localparam logic [2:0] WR_REPLY_LEN = 3'd1;
    localparam logic [2:0] RD_REPLY_LEN = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_WDATA,
        S_WRITE,
        S_READ,
        S_RD_WAIT,
        S_REPLY
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic              is_write;
    logic [1:0]        byte_cnt;
    logic [23:0]       wr_shift;
    logic [31:0]       rd_data;
    logic [2:0]        reply_len;
    logic [2:0]        reply_idx;
    logic [7:0]        reply_byte;
    logic [ADDR_W-1:0] addr_ext;
    logic              timeout;
    logic              last_reply_byte;

    // -----------------------------------------------------------------------
    // Address byte fitted to ADDR_W
    // -----------------------------------------------------------------------
    generate
        if (ADDR_W > 8) begin : g_addr_wide
            assign addr_ext = {{(ADDR_W-8){1'b0}}, ipRxData};
        end else if (ADDR_W == 8) begin : g_addr_exact
            assign addr_ext = ipRxData;
        end else begin : g_addr_narrow
            assign addr_ext = ipRxData[ADDR_W-1:0];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Inter-byte timeout
    // -----------------------------------------------------------------------
`ifdef INTER_BYTE_TIMEOUT_EN
    // Counter only ever reaches TIMEOUT_CYCLES-1 before the frame is dropped.
    localparam int GAP_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [GAP_W-1:0] gap_cnt;
    logic             in_frame;

    assign in_frame = (state_q == S_CMD) || (state_q == S_ADDR) ||
                      (state_q == S_WDATA);

    always_ff @(posedge ipClk) begin
        if (ipReset) begin
            gap_cnt <= '0;
        end else if (!in_frame || ipRxValid) begin
            gap_cnt <= '0;
        end else begin
            gap_cnt <= gap_cnt + 1'b1;
        end
    end

    // The cycle that would be the TIMEOUT_CYCLES-th one without a byte.
    assign timeout = in_frame && !ipRxValid &&
                     (gap_cnt == GAP_W'(TIMEOUT_CYCLES - 1));
`else
    // Keeps TIMEOUT_CYCLES referenced in builds without the timeout.
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

    assign timeout = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Reply byte selection
    // -----------------------------------------------------------------------
    always_comb begin
        reply_byte = ACK_BYTE;
        case (reply_idx)
            3'd1:    reply_byte = rd_data[31:24];
            3'd2:    reply_byte = rd_data[23:16];
            3'd3:    reply_byte = rd_data[15:8];
            3'd4:    reply_byte = rd_data[7:0];
            default: reply_byte = ACK_BYTE;
        endcase
    end

    // Current byte is being accepted by the transmitter and is the last one.
    assign last_reply_byte = opTxSend && ipTxBusy &&
                             (reply_idx == (reply_len - 3'd1));

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge ipClk) begin
        if (ipReset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next state and strobes
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        opWrEnable = 1'b0;
        opRdEnable = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ipRxValid && (ipRxData == SYNC_BYTE)) begin
                    state_d = S_CMD;
                end
            end

            S_CMD: begin
                if (timeout) begin
                    state_d = S_IDLE;
                end else if (ipRxValid) begin
                    if ((ipRxData == CMD_READ) || (ipRxData == CMD_WRITE)) begin
                        state_d = S_ADDR;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            S_ADDR: begin
                if (timeout) begin
                    state_d = S_IDLE;
                end else if (ipRxValid) begin
                    state_d = is_write ? S_WDATA : S_READ;
                end
            end

            S_WDATA: begin
                if (timeout) begin
                    state_d = S_IDLE;
                end else if (ipRxValid && (byte_cnt == 2'd3)) begin
                    state_d = S_WRITE;
                end
            end

            S_WRITE: begin
                opWrEnable = 1'b1;
                state_d    = S_REPLY;
            end

            S_READ: begin
                opRdEnable = 1'b1;
                // Data returned in the strobe cycle itself is taken directly.
                state_d    = ipRdValid ? S_REPLY : S_RD_WAIT;
            end

            S_RD_WAIT: begin
                if (ipRdValid) begin
                    state_d = S_REPLY;
                end
            end

            S_REPLY: begin
                if (last_reply_byte) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath: frame capture, read data, transmit handshake
    // -----------------------------------------------------------------------
    always_ff @(posedge ipClk) begin
        if (ipReset) begin
            opAddress <= '0;
            opWrData  <= '0;
            opTxData  <= '0;
            opTxSend  <= 1'b0;
            is_write  <= 1'b0;
            byte_cnt  <= '0;
            wr_shift  <= '0;
            rd_data   <= '0;
            reply_len <= '0;
            reply_idx <= '0;
        end else begin
            case (state_q)
                S_CMD: begin
                    if (ipRxValid) begin
                        is_write <= (ipRxData == CMD_WRITE);
                    end
                end

                S_ADDR: begin
                    if (ipRxValid) begin
                        opAddress <= addr_ext;
                        byte_cnt  <= '0;
                    end
                end

                S_WDATA: begin
                    // Bytes collect in a shadow so opWrData only changes
                    // once the full word is present.
                    if (ipRxValid) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        wr_shift <= {wr_shift[15:0], ipRxData};
                        if (byte_cnt == 2'd3) begin
                            opWrData <= {wr_shift, ipRxData};
                        end
                    end
                end

                S_WRITE: begin
                    reply_len <= WR_REPLY_LEN;
                    reply_idx <= '0;
                end

                S_READ, S_RD_WAIT: begin
                    if (ipRdValid) begin
                        rd_data   <= ipRdData;
                        reply_len <= RD_REPLY_LEN;
                        reply_idx <= '0;
                    end
                end

                S_REPLY: begin
                    if (opTxSend) begin
                        if (ipTxBusy) begin
                            opTxSend  <= 1'b0;
                            reply_idx <= reply_idx + 3'd1;
                        end
                    end else if (!ipTxBusy) begin
                        opTxData <= reply_byte;
                        opTxSend <= 1'b1;
                    end
                end

                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_reg_bridge.sv
module tb_uart_reg_bridge;

    logic        ipClk = 1'b0;
    logic        ipReset;
    logic [7:0]  ipRxData;
    logic        ipRxValid;
    logic [7:0]  opTxData;
    logic        opTxSend;
    logic        ipTxBusy;
    logic [7:0]  opAddress;
    logic [31:0] opWrData;
    logic        opWrEnable;
    logic        opRdEnable;
    logic [31:0] ipRdData;
    logic        ipRdValid;

    always #5 ipClk = ~ipClk;

    uart_reg_bridge #(.ADDR_W(8), .TIMEOUT_CYCLES(100)) dut (
        .ipClk      (ipClk),
        .ipReset    (ipReset),
        .ipRxData   (ipRxData),
        .ipRxValid  (ipRxValid),
        .opTxData   (opTxData),
        .opTxSend   (opTxSend),
        .ipTxBusy   (ipTxBusy),
        .opAddress  (opAddress),
        .opWrData   (opWrData),
        .opWrEnable (opWrEnable),
        .opRdEnable (opRdEnable),
        .ipRdData   (ipRdData),
        .ipRdValid  (ipRdValid)
    );

    int checks = 0;
    int errors = 0;

    // Observed traffic
    logic [7:0]  tx_q[$];
    logic [7:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [7:0]  rd_addr_q[$];
    logic [31:0] rd_data_q[$];
    int          both_cnt = 0;
    int          tx_bad   = 0;

    // Responder knobs
    int          rd_delay      = 0;
    bit          rd_fixed      = 0;
    logic [31:0] rd_fixed_data = 32'h0;
    int          tx_delay_max  = 2;
    int          tx_busy_len   = 2;
    bit          tx_hold       = 0;

    // Reference model
    typedef struct {
        bit          is_wr;
        logic [7:0]  addr;
        logic [31:0] data;
    } op_t;

    logic [7:0] stream[$];
    op_t        exp_ops[$];
    logic [7:0] exp_tx[$];

    // Strobe monitor
    always @(negedge ipClk) begin
        if (ipReset === 1'b0) begin
            if (opWrEnable === 1'b1) begin
                wr_addr_q.push_back(opAddress);
                wr_data_q.push_back(opWrData);
            end
            if (opRdEnable === 1'b1) rd_addr_q.push_back(opAddress);
            if (opWrEnable === 1'b1 && opRdEnable === 1'b1) both_cnt++;
        end
    end

    // Register read responder
    initial begin
        ipRdValid = 1'b0;
        ipRdData  = 32'h0;
        forever begin
            @(negedge ipClk);
            if (opRdEnable === 1'b1 && ipReset === 1'b0) begin
                repeat (rd_delay) @(negedge ipClk);
                ipRdData  = rd_fixed ? rd_fixed_data : $urandom;
                ipRdValid = 1'b1;
                rd_data_q.push_back(ipRdData);
                @(negedge ipClk);
                ipRdValid = 1'b0;
            end
        end
    end

    // UART transmitter model: accepts a byte after a random delay, then is
    // busy for tx_busy_len cycles. Request and data must stay put until busy
    // is raised, and no new request may appear while busy.
    initial begin
        logic [7:0] held;
        int         d;
        ipTxBusy = 1'b0;
        forever begin
            @(negedge ipClk);
            if (!tx_hold && opTxSend === 1'b1) begin
                held = opTxData;
                d    = $urandom_range(tx_delay_max, 0);
                repeat (d) begin
                    @(negedge ipClk);
                    if (opTxSend !== 1'b1 || opTxData !== held) tx_bad++;
                end
                ipTxBusy = 1'b1;
                tx_q.push_back(held);
                repeat (tx_busy_len) begin
                    @(negedge ipClk);
                    if (opTxSend !== 1'b0 || opTxData !== held) tx_bad++;
                end
                ipTxBusy = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge ipClk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge ipClk);
        ipRxData  = b;
        ipRxValid = 1'b1;
        @(negedge ipClk);
        ipRxValid = 1'b0;
    endtask

    task automatic clear_obs();
        tx_q.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
        rd_addr_q.delete();
        rd_data_q.delete();
    endtask

    task automatic wait_tx(input int n, input int budget, input string tag);
        int c = 0;
        while (tx_q.size() < n && c < budget) begin
            @(negedge ipClk);
            c++;
        end
        checks++;
        if (tx_q.size() < n) begin
            errors++;
            $display("FAIL %s tx_wait: got %0d bytes, required %0d", tag, tx_q.size(), n);
        end
        tick(3);
    endtask

    task automatic pulse_reset();
        ipReset   = 1'b1;
        ipRxValid = 1'b0;
        tick(2);
        ipReset = 1'b0;
    endtask

    // Parse the received byte stream into the accesses it should produce.
    task automatic model_parse();
        int  i = 0;
        int  n = stream.size();
        op_t op;
        exp_ops.delete();
        while (i < n) begin
            if (stream[i] != 8'h55) begin
                i++;
                continue;
            end
            if (i + 1 >= n) break;
            if (stream[i+1] > 8'h01) begin
                i += 2;
                continue;
            end
            if (i + 2 >= n) break;
            op.is_wr = (stream[i+1] == 8'h01);
            op.addr  = stream[i+2];
            op.data  = 32'h0;
            if (op.is_wr) begin
                if (i + 6 >= n) break;
                op.data = {stream[i+3], stream[i+4], stream[i+5], stream[i+6]};
                i += 7;
            end else begin
                i += 3;
            end
            exp_ops.push_back(op);
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        ipReset   = 1'b1;
        ipRxValid = 1'b0;
        ipRxData  = 8'h00;
        tick(3);
        checks++; if (opTxData   !== 8'h00) begin errors++; $display("FAIL reset_txdata: got %h want 00", opTxData); end
        checks++; if (opTxSend   !== 1'b0)  begin errors++; $display("FAIL reset_txsend: got %b want 0", opTxSend); end
        checks++; if (opAddress  !== 8'h00) begin errors++; $display("FAIL reset_addr: got %h want 00", opAddress); end
        checks++; if (opWrData   !== 32'h0) begin errors++; $display("FAIL reset_wrdata: got %h want 0", opWrData); end
        checks++; if (opWrEnable !== 1'b0)  begin errors++; $display("FAIL reset_wren: got %b want 0", opWrEnable); end
        checks++; if (opRdEnable !== 1'b0)  begin errors++; $display("FAIL reset_rden: got %b want 0", opRdEnable); end
        // Sync byte presented while reset is high must be ignored.
        ipRxData  = 8'h55;
        ipRxValid = 1'b1;
        tick(1);
        ipRxValid = 1'b0;
        ipReset   = 1'b0;
        send_byte(8'h00, 0);
        send_byte(8'h10, 0);
        tick(10);
        checks++; if (rd_addr_q.size() !== 0) begin errors++; $display("FAIL reset_wins_rd: got %0d reads want 0", rd_addr_q.size()); end
        checks++; if (tx_q.size() !== 0) begin errors++; $display("FAIL reset_wins_tx: got %0d bytes want 0", tx_q.size()); end
    endtask

    task automatic test_write_latency();
        clear_obs();
        send_byte(8'h55, 1);
        send_byte(8'h01, 1);
        send_byte(8'h10, 1);
        send_byte(8'hDE, 1);
        send_byte(8'hAD, 1);
        send_byte(8'hBE, 1);
        send_byte(8'hEF, 1);
        checks++; if (opWrEnable !== 1'b1) begin errors++; $display("FAIL wr_latency: wren got %b want 1", opWrEnable); end
        checks++; if (opAddress !== 8'h10) begin errors++; $display("FAIL wr_addr: got %h want 10", opAddress); end
        checks++; if (opWrData !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_data: got %h want deadbeef", opWrData); end
        checks++; if (opRdEnable !== 1'b0) begin errors++; $display("FAIL wr_rden: got %b want 0", opRdEnable); end
        tick(1);
        checks++; if (opWrEnable !== 1'b0) begin errors++; $display("FAIL wr_width: wren got %b want 0", opWrEnable); end
        wait_tx(1, 200, "wr_reply");
        checks++; if (tx_q.size() !== 1 || tx_q[0] !== 8'hAA) begin errors++; $display("FAIL wr_reply: got %0d bytes first %h want 1 byte aa", tx_q.size(), (tx_q.size() > 0) ? tx_q[0] : 8'hxx); end
        checks++; if (wr_addr_q.size() !== 1) begin errors++; $display("FAIL wr_count: got %0d want 1", wr_addr_q.size()); end
    endtask

    task automatic test_read_wait();
        logic [7:0] want[5];
        clear_obs();
        want = '{8'hAA, 8'h12, 8'h34, 8'h56, 8'h78};
        rd_delay      = 3;
        rd_fixed      = 1;
        rd_fixed_data = 32'h12345678;
        tx_delay_max  = 3;
        tx_busy_len   = 3;
        send_byte(8'h55, 0);
        send_byte(8'h00, 0);
        send_byte(8'h22, 0);
        wait_tx(5, 400, "rd_reply");
        rd_fixed = 0;
        checks++; if (rd_addr_q.size() !== 1 || rd_addr_q[0] !== 8'h22) begin errors++; $display("FAIL rd_addr: got %0d reads first %h want 1 read at 22", rd_addr_q.size(), (rd_addr_q.size() > 0) ? rd_addr_q[0] : 8'hxx); end
        checks++; if (tx_q.size() !== 5) begin errors++; $display("FAIL rd_reply_len: got %0d want 5", tx_q.size()); end
        for (int i = 0; i < 5 && i < tx_q.size(); i++) begin
            checks++;
            if (tx_q[i] !== want[i]) begin errors++; $display("FAIL rd_reply_byte%0d: got %h want %h", i, tx_q[i], want[i]); end
        end
        checks++; if (wr_addr_q.size() !== 0) begin errors++; $display("FAIL rd_no_write: got %0d writes want 0", wr_addr_q.size()); end
    endtask

    task automatic test_bad_cmd();
        clear_obs();
        rd_delay = 0;
        send_byte(8'h41, 0);
        send_byte(8'h55, 0);
        send_byte(8'h07, 0);
        tick(20);
        checks++; if (tx_q.size() !== 0) begin errors++; $display("FAIL badcmd_noreply: got %0d bytes want 0", tx_q.size()); end
        send_byte(8'h55, 0);
        send_byte(8'h01, 0);
        send_byte(8'h05, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        wait_tx(1, 200, "badcmd_reply");
        checks++; if (wr_addr_q.size() !== 1) begin errors++; $display("FAIL badcmd_wr_count: got %0d want 1", wr_addr_q.size()); end
        if (wr_addr_q.size() > 0) begin
            checks++; if (wr_addr_q[0] !== 8'h05) begin errors++; $display("FAIL badcmd_wr_addr: got %h want 05", wr_addr_q[0]); end
            checks++; if (wr_data_q[0] !== 32'h1) begin errors++; $display("FAIL badcmd_wr_data: got %h want 00000001", wr_data_q[0]); end
        end
        checks++; if (tx_q.size() !== 1 || tx_q[0] !== 8'hAA) begin errors++; $display("FAIL badcmd_reply: got %0d bytes want 1 byte aa", tx_q.size()); end
    endtask

    task automatic test_reset_mid_frame();
        clear_obs();
        rd_delay = 1;
        send_byte(8'h55, 0);
        send_byte(8'h01, 0);
        send_byte(8'h10, 0);
        send_byte(8'hDE, 0);
        pulse_reset();
        tick(2);
        send_byte(8'h55, 0);
        send_byte(8'h00, 0);
        send_byte(8'h10, 0);
        wait_tx(5, 300, "rstframe_reply");
        checks++; if (wr_addr_q.size() !== 0) begin errors++; $display("FAIL rstframe_no_write: got %0d writes want 0", wr_addr_q.size()); end
        checks++; if (rd_addr_q.size() !== 1 || rd_addr_q[0] !== 8'h10) begin errors++; $display("FAIL rstframe_read: got %0d reads want 1 at 10", rd_addr_q.size()); end
        checks++; if (tx_q.size() !== 5 || tx_q[0] !== 8'hAA) begin errors++; $display("FAIL rstframe_reply: got %0d bytes want 5 starting aa", tx_q.size()); end
    endtask

    task automatic test_reset_mid_reply();
        clear_obs();
        tx_hold = 1;
        send_byte(8'h55, 0);
        send_byte(8'h01, 0);
        send_byte(8'h33, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h07, 0);
        tick(5);
        checks++; if (opTxSend !== 1'b1) begin errors++; $display("FAIL rstreply_pending: txsend got %b want 1", opTxSend); end
        pulse_reset();
        checks++; if (opTxSend !== 1'b0) begin errors++; $display("FAIL rstreply_cleared: txsend got %b want 0", opTxSend); end
        tx_hold = 0;
        tick(10);
        checks++; if (opTxSend !== 1'b0) begin errors++; $display("FAIL rstreply_stays_idle: txsend got %b want 0", opTxSend); end
        checks++; if (tx_q.size() !== 0) begin errors++; $display("FAIL rstreply_no_bytes: got %0d bytes want 0", tx_q.size()); end
    endtask

    task automatic test_busy_hold();
        logic [7:0] want[5];
        clear_obs();
        tx_bad        = 0;
        rd_delay      = 2;
        rd_fixed      = 1;
        rd_fixed_data = 32'hCAFEF00D;
        want          = '{8'hAA, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
        tx_delay_max  = 20;
        tx_busy_len   = 100;
        send_byte(8'h55, 0);
        send_byte(8'h00, 0);
        send_byte(8'h33, 0);
        // Complete write frame while the bridge is busy with the read.
        send_byte(8'h55, 1);
        send_byte(8'h01, 1);
        send_byte(8'h44, 1);
        send_byte(8'h11, 1);
        send_byte(8'h22, 1);
        send_byte(8'h33, 1);
        send_byte(8'h44, 1);
        wait_tx(5, 1000, "busy_reply");
        rd_fixed = 0;
        tick(110);
        tx_delay_max = 2;
        tx_busy_len  = 2;
        checks++; if (wr_addr_q.size() !== 0) begin errors++; $display("FAIL busy_no_write: got %0d writes want 0", wr_addr_q.size()); end
        checks++; if (rd_addr_q.size() !== 1) begin errors++; $display("FAIL busy_reads: got %0d want 1", rd_addr_q.size()); end
        checks++; if (tx_q.size() !== 5) begin errors++; $display("FAIL busy_reply_len: got %0d want 5", tx_q.size()); end
        for (int i = 0; i < 5 && i < tx_q.size(); i++) begin
            checks++;
            if (tx_q[i] !== want[i]) begin errors++; $display("FAIL busy_reply_byte%0d: got %h want %h", i, tx_q[i], want[i]); end
        end
        checks++; if (tx_bad !== 0) begin errors++; $display("FAIL busy_handshake: %0d violations want 0", tx_bad); end
    endtask

    task automatic test_random_frames();
        int          exp_n = 0;
        int          k     = 0;
        int          n_wr  = 0;
        int          n_rd  = 0;
        logic [7:0]  frm[$];
        logic [7:0]  b;
        logic [31:0] d;
        bit          is_wr;
        clear_obs();
        stream.delete();
        for (int f = 0; f < 24; f++) begin
            frm.delete();
            for (int j = $urandom_range(2, 0); j > 0; j--) begin
                if ($urandom_range(1, 0) == 1) begin
                    b = 8'($urandom_range(255, 0));
                    if (b == 8'h55) b = 8'h56;
                    frm.push_back(b);
                end else begin
                    frm.push_back(8'h55);
                    frm.push_back(8'($urandom_range(255, 2)));
                end
            end
            is_wr = ($urandom_range(1, 0) == 1);
            frm.push_back(8'h55);
            frm.push_back(is_wr ? 8'h01 : 8'h00);
            frm.push_back(8'($urandom_range(255, 0)));
            if (is_wr) begin
                d = $urandom;
                frm.push_back(d[31:24]);
                frm.push_back(d[23:16]);
                frm.push_back(d[15:8]);
                frm.push_back(d[7:0]);
            end
            rd_delay = $urandom_range(4, 0);
            foreach (frm[j]) begin
                stream.push_back(frm[j]);
                send_byte(frm[j], $urandom_range(2, 0));
            end
            exp_n += is_wr ? 1 : 5;
            wait_tx(exp_n, 300, "rand_reply");
        end
        model_parse();
        foreach (exp_ops[i]) begin
            exp_tx.push_back(8'hAA);
            if (exp_ops[i].is_wr) begin
                if (n_wr < wr_addr_q.size()) begin
                    checks++;
                    if (wr_addr_q[n_wr] !== exp_ops[i].addr || wr_data_q[n_wr] !== exp_ops[i].data) begin
                        errors++;
                        $display("FAIL rand_write%0d: got %h/%h want %h/%h", n_wr, wr_addr_q[n_wr], wr_data_q[n_wr], exp_ops[i].addr, exp_ops[i].data);
                    end
                end
                n_wr++;
            end else begin
                if (n_rd < rd_addr_q.size()) begin
                    checks++;
                    if (rd_addr_q[n_rd] !== exp_ops[i].addr) begin
                        errors++;
                        $display("FAIL rand_read%0d: got %h want %h", n_rd, rd_addr_q[n_rd], exp_ops[i].addr);
                    end
                end
                if (k < rd_data_q.size()) begin
                    d = rd_data_q[k];
                    exp_tx.push_back(d[31:24]);
                    exp_tx.push_back(d[23:16]);
                    exp_tx.push_back(d[15:8]);
                    exp_tx.push_back(d[7:0]);
                end
                k++;
                n_rd++;
            end
        end
        checks++; if (wr_addr_q.size() !== n_wr) begin errors++; $display("FAIL rand_wr_count: got %0d want %0d", wr_addr_q.size(), n_wr); end
        checks++; if (rd_addr_q.size() !== n_rd) begin errors++; $display("FAIL rand_rd_count: got %0d want %0d", rd_addr_q.size(), n_rd); end
        checks++; if (tx_q.size() !== exp_tx.size()) begin errors++; $display("FAIL rand_tx_count: got %0d want %0d", tx_q.size(), exp_tx.size()); end
        for (int i = 0; i < exp_tx.size() && i < tx_q.size(); i++) begin
            checks++;
            if (tx_q[i] !== exp_tx[i]) begin errors++; $display("FAIL rand_tx%0d: got %h want %h", i, tx_q[i], exp_tx[i]); end
        end
    endtask

`ifdef INTER_BYTE_TIMEOUT_EN
    task automatic test_timeout();
        clear_obs();
        rd_delay = 1;
        // Gap well inside the limit: frame completes.
        send_byte(8'h55, 0);
        send_byte(8'h01, 0);
        send_byte(8'h02, 90);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h09, 0);
        wait_tx(1, 200, "tmo_short_gap");
        checks++; if (wr_addr_q.size() !== 1 || wr_addr_q[0] !== 8'h02) begin errors++; $display("FAIL tmo_short_gap_write: got %0d writes want 1 at 02", wr_addr_q.size()); end
        tick(10);
        clear_obs();
        // Gap past the limit: partial write is dropped, read follows.
        send_byte(8'h55, 0);
        send_byte(8'h01, 0);
        send_byte(8'h55, 101);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        wait_tx(5, 300, "tmo_reply");
        checks++; if (wr_addr_q.size() !== 0) begin errors++; $display("FAIL tmo_no_write: got %0d writes want 0", wr_addr_q.size()); end
        checks++; if (rd_addr_q.size() !== 1 || rd_addr_q[0] !== 8'h01) begin errors++; $display("FAIL tmo_read: got %0d reads want 1 at 01", rd_addr_q.size()); end
    endtask
`endif

    task automatic test_exclusive();
        checks++; if (both_cnt !== 0) begin errors++; $display("FAIL strobe_exclusive: %0d overlaps want 0", both_cnt); end
        checks++; if (tx_bad !== 0) begin errors++; $display("FAIL tx_handshake: %0d violations want 0", tx_bad); end
    endtask

    initial begin
        ipReset   = 1'b1;
        ipRxValid = 1'b0;
        ipRxData  = 8'h00;
        test_reset();
        test_write_latency();
        test_read_wait();
        test_bad_cmd();
        test_reset_mid_frame();
        test_reset_mid_reply();
        test_busy_hold();
        test_random_frames();
`ifdef INTER_BYTE_TIMEOUT_EN
        test_timeout();
`endif
        test_exclusive();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
